// File: rtl/iomem_timer.sv
// -----------------------------------------------------------------------------
// iomem_timer
//
// Multi-channel periodic / one-shot timer on a simple valid/ready memory bus.
// Each channel has a free-running counter that compares against a programmable
// PERIOD. When the counter reaches PERIOD the channel output q toggles, the
// counter restarts from zero and the channel's sticky EXPIRED flag is set.
//
// Register map (per channel, channel = addr[7:4], register = addr[3:2]):
//   0 CTRL   : bit0 EN, bit1 ONESHOT, bit2 IE, bit3 Q (read-only)
//   1 PERIOD : [WIDTH-1:0], byte-writable through iomem_wstrb
//   2 COUNT  : read-only
//   3 STATUS : bit0 EXPIRED, write 1 to clear
//
// Configuration macro:
//   IOMEM_TIMER_IRQ_EN  defined   -> irq is the registered OR of EXPIRED & IE
//                       undefined -> irq tied low, IE reads 0, IE writes ignored
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   iomem_valid  in   bus request valid
//   iomem_wstrb  in   [3:0] byte write strobes, 0 means read
//   iomem_addr   in   [31:0] address; [31:24] selects this peripheral
//   iomem_wdata  in   [31:0] write data
//   iomem_ready  out  one-cycle registered acknowledge
//   iomem_rdata  out  [31:0] registered read data
//   q            out  [CHANNELS-1:0] per-channel toggle outputs
//   irq          out  interrupt request
// -----------------------------------------------------------------------------
module iomem_timer #(
    parameter int         CHANNELS = 4,
    parameter int         WIDTH    = 24,
    parameter logic [7:0] ADDR_HI  = 8'h05
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iomem_valid,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic                iomem_ready,
    output logic [31:0]         iomem_rdata,
    output logic [CHANNELS-1:0] q,
    output logic                irq
);

`ifdef IOMEM_TIMER_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    localparam logic [1:0]       REG_CTRL   = 2'd0;
    localparam logic [1:0]       REG_PERIOD = 2'd1;
    localparam logic [1:0]       REG_COUNT  = 2'd2;
    localparam logic [1:0]       REG_STATUS = 2'd3;
    localparam logic [4:0]       CH_LIMIT   = 5'(CHANNELS);
    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                ready_q,   ready_d;
    logic [31:0]         rdata_q,   rdata_d;
    logic                irq_q,     irq_d;
    logic [CHANNELS-1:0] en_q,      en_d;
    logic [CHANNELS-1:0] oneshot_q, oneshot_d;
    logic [CHANNELS-1:0] ie_q,      ie_d;
    logic [CHANNELS-1:0] q_q,       q_d;
    logic [CHANNELS-1:0] expired_q, expired_d;
    logic [WIDTH-1:0]    period_q   [CHANNELS];
    logic [WIDTH-1:0]    period_d   [CHANNELS];
    logic [WIDTH-1:0]    count_q    [CHANNELS];
    logic [WIDTH-1:0]    count_d    [CHANNELS];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic       is_write;
    logic       ch_valid;
    logic [3:0] ch_idx;
    logic [1:0] reg_idx;

    // Blocking the select while ready_q is high keeps a held request from
    // being acknowledged twice in a row.
    assign sel      = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
    assign ch_idx   = iomem_addr[7:4];
    assign reg_idx  = iomem_addr[3:2];
    assign is_write = |iomem_wstrb;
    assign ch_valid = ({1'b0, ch_idx} < CH_LIMIT);

    // Address bits that carry no meaning for this peripheral.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iomem_addr[23:8], iomem_addr[1:0]};

    // ------------------------------------------------------------------
    // Fetch the addressed channel's registers (zero for absent channels)
    // ------------------------------------------------------------------
    logic             sel_en, sel_oneshot, sel_ie, sel_qbit, sel_expired;
    logic [WIDTH-1:0] sel_period;
    logic [WIDTH-1:0] sel_count;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned and
        // infer a latch.
        sel_en      = 1'b0;
        sel_oneshot = 1'b0;
        sel_ie      = 1'b0;
        sel_qbit    = 1'b0;
        sel_expired = 1'b0;
        sel_period  = '0;
        sel_count   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 4'(c)) begin
                sel_en      = en_q[c];
                sel_oneshot = oneshot_q[c];
                sel_ie      = ie_q[c];
                sel_qbit    = q_q[c];
                sel_expired = expired_q[c];
                sel_period  = period_q[c];
                sel_count   = count_q[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data and PERIOD byte-merge
    // ------------------------------------------------------------------
    logic [31:0] rd_value;
    logic [31:0] period_word;

    always_comb begin
        rd_value = '0;
        if (ch_valid) begin
            case (reg_idx)
                REG_CTRL:   rd_value[3:0]       = {sel_qbit, sel_ie, sel_oneshot, sel_en};
                REG_PERIOD: rd_value[WIDTH-1:0] = sel_period;
                REG_COUNT:  rd_value[WIDTH-1:0] = sel_count;
                REG_STATUS: rd_value[0]         = sel_expired;
                default:    rd_value            = '0;
            endcase
        end

        // Only strobed bytes change; bytes above WIDTH fall away on truncation.
        period_word = 32'(sel_period);
        for (int b = 0; b < 4; b++) begin
            if (iomem_wstrb[b]) begin
                period_word[8*b +: 8] = iomem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        ready_d = sel;
        rdata_d = sel ? rd_value : rdata_q;
    end

    // ------------------------------------------------------------------
    // Channel next-state
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] expire;
    logic [CHANNELS-1:0] wr_hit;

    always_comb begin
        expire = '0;
        wr_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            en_d[c]      = en_q[c];
            oneshot_d[c] = oneshot_q[c];
            ie_d[c]      = ie_q[c];
            q_d[c]       = q_q[c];
            expired_d[c] = expired_q[c];
            period_d[c]  = period_q[c];
            count_d[c]   = count_q[c];

            // ">=" rather than "==" so lowering PERIOD below the running
            // count expires at once instead of wrapping through 2^WIDTH.
            expire[c] = en_q[c] && (count_q[c] >= period_q[c]);
            wr_hit[c] = sel && is_write && ch_valid && (ch_idx == 4'(c));

            if (expire[c]) begin
                q_d[c]     = ~q_q[c];
                count_d[c] = '0;
                if (oneshot_q[c]) begin
                    en_d[c] = 1'b0;
                end
            end else if (en_q[c]) begin
                count_d[c] = count_q[c] + COUNT_ONE;
            end

            // A CTRL write overrides the timer's own EN/COUNT update: setting
            // EN restarts from zero, clearing EN freezes the count where it
            // was. The toggle computed above still happens.
            if (wr_hit[c] && (reg_idx == REG_CTRL) && iomem_wstrb[0]) begin
                en_d[c]      = iomem_wdata[0];
                oneshot_d[c] = iomem_wdata[1];
                ie_d[c]      = IRQ_EN && iomem_wdata[2];
                count_d[c]   = iomem_wdata[0] ? '0 : count_q[c];
            end

            if (wr_hit[c] && (reg_idx == REG_PERIOD)) begin
                period_d[c] = period_word[WIDTH-1:0];
            end

            if (wr_hit[c] && (reg_idx == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[0]) begin
                expired_d[c] = 1'b0;
            end

            // Set after the clear so an expiry in the same cycle wins.
            if (expire[c]) begin
                expired_d[c] = 1'b1;
            end
        end
    end

`ifdef IOMEM_TIMER_IRQ_EN
    always_comb irq_d = |(expired_q & ie_q);
`else
    always_comb irq_d = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            en_q      <= '0;
            oneshot_q <= '0;
            ie_q      <= '0;
            q_q       <= '0;
            expired_q <= '0;
            // NOTE: these per-channel arrays are architectural registers the
            // software sees after reset, so they are cleared like any flop
            // rather than treated as uninitialised storage.
            for (int c = 0; c < CHANNELS; c++) begin
                period_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            ie_q      <= ie_d;
            q_q       <= q_d;
            expired_q <= expired_d;
            period_q  <= period_d;
            count_q   <= count_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign q           = q_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_timer.sv
// -----------------------------------------------------------------------------
// tb_iomem_timer
//
// Directed testbench for iomem_timer (CHANNELS=4, WIDTH=24, ADDR_HI=8'h05).
// Expected timer values come from a tiny model: after an arming write at edge
// c_arm, COUNT after edge c is (c - c_arm) % (PERIOD+1) and q has toggled
// (c - c_arm) / (PERIOD+1) times. A bus read sampled at edge c returns the
// register contents from before that edge.
// -----------------------------------------------------------------------------
module tb_iomem_timer;

`ifdef IOMEM_TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic [3:0]  q;
    logic        irq;

    iomem_timer #(
        .CHANNELS (4),
        .WIDTH    (24),
        .ADDR_HI  (8'h05)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .q           (q),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Edge counter: at #1 after a rising edge, cyc is that edge's index.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction: request presented before edge e, ready/rdata
    // sampled after e, ready must be gone after e+1. Returns at e+1 (+1).
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output int edge_c);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        @(posedge clk);
        #1;
        edge_c = cyc;
        rd     = iomem_rdata;
        check("ready_pulse", 32'(iomem_ready), 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("ready_one_cycle", 32'(iomem_ready), 32'd0);
    endtask

    // Watchdog: every wait below is a fixed cycle count, this only guards
    // against a stuck simulator.
    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    int          ec;
    int          c_arm, c_stop, c1, c2, cw, c3, cs, c0;
    int          q_frz, cnt_frz, qb;

    initial begin
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- selected vs unselected request ----------------
        bus(32'h0500_0008, 4'h0, 32'h0, rd, ec);
        check("count_after_reset", rd, 32'd0);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("unselected_no_ready", 32'(iomem_ready), 32'd0);
        end
        iomem_valid = 1'b0;

        // ---------------- ch0 periodic, PERIOD=3 ----------------
        bus(32'h0500_0004, 4'hF, 32'd3, rd, ec);
        bus(32'h0500_0004, 4'h0, 32'h0, rd, ec);
        check("ch0_period_rb", rd, 32'd3);
        bus(32'h0500_0000, 4'h1, 32'h1, rd, c_arm);
        for (int i = 0; i < 12; i++) begin
            check("ch0_q_toggle", 32'(q[0]), 32'(((cyc - c_arm) / 4) % 2));
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            bus(32'h0500_0008, 4'h0, 32'h0, rd, ec);
            check("ch0_count_cycle", rd, 32'((ec - 1 - c_arm) % 4));
            @(posedge clk);
        end
        bus(32'h0500_0000, 4'h0, 32'h0, rd, ec);
        qb = ((ec - 1 - c_arm) / 4) % 2;
        check("ch0_ctrl_rb", rd, 32'(1 + 8 * qb));

        // Stop: count and q must freeze.
        bus(32'h0500_0000, 4'h1, 32'h0, rd, c_stop);
        q_frz   = ((c_stop - c_arm) / 4) % 2;
        cnt_frz = (c_stop - 1 - c_arm) % 4;
        repeat (5) @(posedge clk);
        #1;
        check("ch0_q_hold", 32'(q[0]), 32'(q_frz));
        bus(32'h0500_0008, 4'h0, 32'h0, rd, ec);
        check("ch0_count_hold", rd, 32'(cnt_frz));

        // ---------------- ch1 PERIOD byte strobes ----------------
        bus(32'h0500_0014, 4'b0001, 32'hAABB_CC0A, rd, ec);
        bus(32'h0500_0014, 4'h0, 32'h0, rd, ec);
        check("ch1_period_b0", rd, 32'h0000_000A);
        bus(32'h0500_0014, 4'b0100, 32'h0012_0000, rd, ec);
        bus(32'h0500_0014, 4'h0, 32'h0, rd, ec);
        check("ch1_period_b2", rd, 32'h0012_000A);
        bus(32'h0500_0014, 4'b1000, 32'hFF00_0000, rd, ec);
        bus(32'h0500_0014, 4'h0, 32'h0, rd, ec);
        check("ch1_period_b3_ignored", rd, 32'h0012_000A);
        bus(32'h0500_0014, 4'b0100, 32'h0, rd, ec);
        bus(32'h0500_0014, 4'h0, 32'h0, rd, ec);
        check("ch1_period_10", rd, 32'd10);

        // ---------------- ch1 one-shot, PERIOD=10 ----------------
        bus(32'h0500_0010, 4'h1, 32'h3, rd, c1);
        for (int i = 0; i < 20; i++) begin
            check("ch1_oneshot_q", 32'(q[1]), 32'((cyc - c1) >= 11));
            @(posedge clk);
            #1;
        end
        bus(32'h0500_0010, 4'h0, 32'h0, rd, ec);
        check("ch1_ctrl_after_shot", rd, 32'hA);
        bus(32'h0500_001C, 4'h0, 32'h0, rd, ec);
        check("ch1_status_set", rd, 32'd1);
        check("ch1_no_irq_ie0", 32'(irq), 32'd0);
        bus(32'h0500_001C, 4'h1, 32'h1, rd, ec);
        bus(32'h0500_001C, 4'h0, 32'h0, rd, ec);
        check("ch1_status_w1c", rd, 32'd0);

        // ---------------- ch2 PERIOD lowered below COUNT ----------------
        bus(32'h0500_0024, 4'hF, 32'd100, rd, ec);
        bus(32'h0500_0020, 4'h1, 32'h1, rd, c2);
        repeat (18) @(posedge clk);
        #1;
        check("ch2_no_early_toggle", 32'(q[2]), 32'd0);
        bus(32'h0500_0024, 4'hF, 32'd5, rd, cw);
        check("ch2_count_was_20", 32'(cw - c2), 32'd20);
        check("ch2_expire_next", 32'(q[2]), 32'd1);
        bus(32'h0500_0028, 4'h0, 32'h0, rd, ec);
        check("ch2_count_restart", rd, 32'((ec - 2 - cw) % 6));
        bus(32'h0500_002C, 4'h0, 32'h0, rd, ec);
        check("ch2_status", rd, 32'd1);
        bus(32'h0500_0020, 4'h1, 32'h0, rd, ec);

        // ---------------- absent channels ----------------
        bus(32'h0500_0054, 4'hF, 32'h77, rd, ec);
        bus(32'h0500_0054, 4'h0, 32'h0, rd, ec);
        check("ch5_period_zero", rd, 32'd0);
        bus(32'h0500_00F0, 4'h0, 32'h0, rd, ec);
        check("ch15_ctrl_zero", rd, 32'd0);
        bus(32'h0500_0014, 4'h0, 32'h0, rd, ec);
        check("ch1_not_aliased", rd, 32'd10);

        // ---------------- ch3 interrupt / expiry vs W1C ----------------
        bus(32'h0500_0034, 4'hF, 32'd3, rd, ec);
        bus(32'h0500_0030, 4'h1, 32'h5, rd, c3);
        repeat (4) @(posedge clk);
        #1;
        check("ch3_irq_rise", 32'(irq), 32'(IRQ_ON));
        repeat (2) @(posedge clk);
        bus(32'h0500_003C, 4'h1, 32'h1, rd, cs);
        check("ch3_w1c_on_expiry_edge", 32'(cs - c3), 32'd8);
        check("ch3_irq_held", 32'(irq), 32'(IRQ_ON));
        bus(32'h0500_003C, 4'h0, 32'h0, rd, ec);
        check("ch3_expiry_wins", rd, 32'd1);
        bus(32'h0500_0030, 4'h0, 32'h0, rd, ec);
        qb = ((ec - 1 - c3) / 4) % 2;
        check("ch3_ctrl_ie", rd, 32'(1 + 4 * int'(IRQ_ON) + 8 * qb));
        bus(32'h0500_0030, 4'h1, 32'h0, rd, ec);
        bus(32'h0500_003C, 4'h1, 32'h1, rd, ec);
        bus(32'h0500_003C, 4'h0, 32'h0, rd, ec);
        check("ch3_status_cleared", rd, 32'd0);
        check("ch3_irq_fall", 32'(irq), 32'd0);

        // ---------------- reset mid-count ----------------
        bus(32'h0500_0004, 4'hF, 32'd100, rd, ec);
        bus(32'h0500_0000, 4'h1, 32'h1, rd, c0);
        bus(32'h0500_0004, 4'h0, 32'h0, rd, ec);
        check("pre_reset_period", rd, 32'd100);
        repeat (47) @(posedge clk);
        @(negedge clk);
        reset       = 1'b1;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0500_0004;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("reset_at_count50", 32'(cyc - 1 - c0), 32'd50);
        check("reset_ready_aborted", 32'(iomem_ready), 32'd0);
        check("reset_rdata", iomem_rdata, 32'd0);
        check("reset_q", 32'(q), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        bus(32'h0500_0004, 4'h0, 32'h0, rd, ec);
        check("post_reset_period", rd, 32'd0);
        bus(32'h0500_0000, 4'h0, 32'h0, rd, ec);
        check("post_reset_ctrl", rd, 32'd0);
        bus(32'h0500_0008, 4'h0, 32'h0, rd, ec);
        check("post_reset_count", rd, 32'd0);
        bus(32'h0500_002C, 4'h0, 32'h0, rd, ec);
        check("post_reset_status", rd, 32'd0);
        check("post_reset_q_idle", 32'(q), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
